// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes for the multi-cycle ops and the sequencer state type.
// No logic, no latency.
// No flow control.
package cpu_pkg;

  localparam logic [4:0] ALU_MULT = 5'b01100;
  localparam logic [4:0] ALU_DIV  = 5'b01101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for MULT, shift/trial-subtract/restore for DIV.
// Purely combinational, zero latency.
// No flow control; the caller decides when to register the result.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // MULT: acc = {partial product, remaining multiplier bits}.
  // DIV:  acc = {remainder, dividend bits shifting into quotient}.
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    // rem_sh < 2*divisor, so bit WIDTH of the wrapped difference is set
    // exactly when the trial subtraction went negative.
    diff   = rem_sh - {1'b0, operand};
    if (is_div) begin
      if (diff[WIDTH]) acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_next = {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/DIV sequencer writing HI/LO; signed mode enabled by `define MULDIV_SIGNED_EN.
// Latency WIDTH+1 cycles from accepted start to done, data independent.
// No queueing: start is only sampled in IDLE; the core must stall while busy is high.
module muldiv_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  muldiv_state_t      state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_step, res;
  logic [WIDTH-1:0]   opnd, a_in, b_in;
  logic               op_div, dz, accept, last, is_muldiv;

  assign is_muldiv = (alu_control == ALU_MULT) || (alu_control == ALU_DIV);
  assign accept    = (state == IDLE) && start && is_muldiv;
  assign last      = (cnt == CW'(WIDTH - 1));

`ifdef MULDIV_SIGNED_EN
  logic sgn_diff, sgn_a;
  // Iterate on magnitudes; the signs are remembered for FIX.
  assign a_in = a[WIDTH-1] ? -a : a;
  assign b_in = b[WIDTH-1] ? -b : b;

  // Sign correction; a zero divisor counts as positive and keeps lo all ones.
  always_comb begin
    res = acc;
    if (op_div) begin
      if (sgn_a)         res[2*WIDTH-1:WIDTH] = -acc[2*WIDTH-1:WIDTH];
      if (dz)            res[WIDTH-1:0]       = '1;
      else if (sgn_diff) res[WIDTH-1:0]       = -acc[WIDTH-1:0];
    end else if (sgn_diff) begin
      res = -acc;
    end
  end
`else
  assign a_in = a;
  assign b_in = b;
  assign res  = acc;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_div),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (acc_step)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: IDLE -> RUN on a valid op, WIDTH iterations, one FIX cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch on acceptance, then one iteration per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_div <= 1'b0;
      dz     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn_diff <= 1'b0;
      sgn_a    <= 1'b0;
`endif
    end else if (accept) begin
      cnt    <= '0;
      op_div <= (alu_control == ALU_DIV);
      dz     <= (alu_control == ALU_DIV) && (b == '0);
      // MULT accumulates a over the bits of b; DIV shifts a through the remainder.
      if (alu_control == ALU_DIV) begin
        acc  <= {{WIDTH{1'b0}}, a_in};
        opnd <= b_in;
      end else begin
        acc  <= {{WIDTH{1'b0}}, b_in};
        opnd <= a_in;
      end
`ifdef MULDIV_SIGNED_EN
      sgn_diff <= a[WIDTH-1] ^ b[WIDTH-1];
      sgn_a    <= a[WIDTH-1];
`endif
    end else if (state == RUN) begin
      acc <= acc_step;
      cnt <= cnt + 1'b1;
    end
  end

  // Registered outputs: busy spans acceptance to FIX exit, done is a single pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (accept) busy <= 1'b1;
      if (state == FIX) begin
        busy        <= 1'b0;
        done        <= 1'b1;
        div_by_zero <= dz;
        hi          <= res[2*WIDTH-1:WIDTH];
        lo          <= res[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table plus multi-cycle corner sequences.
// Expected results are queued at acceptance and compared when done pulses.
// Signed expectations are selected with MULDIV_SIGNED_EN, matching the RTL build.
module tb_muldiv_sequencer;
  import cpu_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   alu_control = 5'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_checks   = 0;
  int n_fail     = 0;
  int done_count = 0;

  logic [2*W:0] exp_q[$];

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[$];

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .alu_control (alu_control),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_count <= done_count + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; presents the op, lets it be accepted, then scrambles inputs.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
    alu_control = op;
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back({edz, eh, el});
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // n0 = negedges already elapsed since acceptance; returns at the negedge where done is seen.
  task automatic finish_op(input string name, input int n0);
    int n;
    bit busy_ok;
    logic [2*W:0] e;
    n = n0;
    busy_ok = 1'b1;
    while (!done && n < LAT + 8) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(LAT));
    check({name, " busy held"}, 64'(busy_ok), 64'd1);
    check({name, " busy falls"}, 64'(busy), 64'd0);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard: got a result, expected none queued", name);
    end else begin
      e = exp_q.pop_front();
      check({name, " hi"}, 64'(hi), 64'(e[2*W-1:W]));
      check({name, " lo"}, 64'(lo), 64'(e[W-1:0]));
      check({name, " dz"}, 64'(div_by_zero), 64'(e[2*W]));
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [W-1:0] ta,
                        input logic [W-1:0] tb_v, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input logic edz);
    @(negedge clk);
    issue(op, ta, tb_v, eh, el, edz);
    finish_op(name, 0);
    @(negedge clk);
    check({name, " done pulse width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int dc;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset dz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;

    vecs.push_back('{ALU_MULT, 32'd7,          32'd6,          32'd0,          32'd42,         1'b0});
    vecs.push_back('{ALU_MULT, 32'h0001_0000,  32'h0001_0000,  32'd1,          32'd0,          1'b0});
    vecs.push_back('{ALU_DIV,  32'd100,        32'd7,          32'd2,          32'd14,         1'b0});
    vecs.push_back('{ALU_DIV,  32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1'b1});
    vecs.push_back('{ALU_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  32'hFFFF_FFFF,  1'b1});
`ifdef MULDIV_SIGNED_EN
    vecs.push_back('{ALU_MULT, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0});
    vecs.push_back('{ALU_MULT, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd1,          1'b0});
    vecs.push_back('{ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  1'b0});
    vecs.push_back('{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0});
    vecs.push_back('{ALU_DIV,  32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  1'b0});
`else
    vecs.push_back('{ALU_MULT, 32'hFFFF_FFFF,  32'd2,          32'd1,          32'hFFFF_FFFE,  1'b0});
    vecs.push_back('{ALU_MULT, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b0});
    vecs.push_back('{ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'd1,          32'h7FFF_FFFC,  1'b0});
    vecs.push_back('{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0});
    vecs.push_back('{ALU_DIV,  32'd7,          32'hFFFF_FFFE,  32'd7,          32'd0,          1'b0});
`endif

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dz);

    // Unsupported control code is ignored
    @(negedge clk);
    dc = done_count;
    alu_control = 5'b01111;
    a = 32'd3;
    b = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("illegal op busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("illegal op busy later", 64'(busy), 64'd0);
    check("illegal op no done", 64'(done_count), 64'(dc));

    // Second start during a MULT is dropped
    @(negedge clk);
    dc = done_count;
    issue(ALU_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    repeat (4) @(negedge clk);
    alu_control = ALU_DIV;
    a = 32'd9;
    b = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op("busy start", 5);
    repeat (2 * LAT) @(negedge clk);
    check("busy start single done", 64'(done_count), 64'(dc + 1));

    // Start in the done cycle is accepted immediately
    @(negedge clk);
    issue(ALU_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    finish_op("b2b first", 0);
    issue(ALU_DIV, 32'd23, 32'd5, 32'd3, 32'd4, 1'b0);
    finish_op("b2b second", 0);

    // Reset in the middle of a DIV aborts it
    @(negedge clk);
    issue(ALU_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    check("abort done", 64'(done), 64'd0);
    @(negedge clk);
    dc = done_count;
    reset = 1'b0;
    repeat (2 * LAT) @(negedge clk);
    check("abort no done", 64'(done_count), 64'(dc));
    run_op("after abort", ALU_MULT, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
